// File: rtl/wb_shadow_snapshot_if.sv
// Valid/ready beat stream carrying one snapshot register per transfer.
interface wb_shadow_snapshot_if #(
    parameter int unsigned REG_WIDTH  = 5,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [REG_WIDTH-1:0]  out_reg_o;
    logic [DATA_WIDTH-1:0] out_data_o;
    logic                  out_last_o;

    modport master (
        output out_valid_o,
        input  out_ready_i,
        output out_reg_o,
        output out_data_o,
        output out_last_o
    );

    modport slave (
        input  out_valid_o,
        output out_ready_i,
        input  out_reg_o,
        input  out_data_o,
        input  out_last_o
    );
endinterface

// File: rtl/wb_shadow_snapshot.sv
// Shadow register file fed by the delayed write-back stream; on trigger it freezes
// a coherent copy and streams the mask-selected registers out lowest index first.
module wb_shadow_snapshot #(
    parameter int unsigned REG_WIDTH  = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 32,
    parameter bit          R0_ZERO    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_enable_i,
    input  logic [REG_WIDTH-1:0]  wb_reg_i,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    input  logic                  trig_i,
    input  logic [NUM_REGS-1:0]   trig_mask_i,
    wb_shadow_snapshot_if.master  out_if,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  trig_dropped_o
);

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_e;

    state_e                state_q;
    logic [DATA_WIDTH-1:0] shadow_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] snap_q   [NUM_REGS];
    logic [DATA_WIDTH-1:0] snap_d   [NUM_REGS];
    logic [DATA_WIDTH-1:0] shadow_fwd_c [NUM_REGS];
    logic [NUM_REGS-1:0]   pending_q;
    logic [NUM_REGS-1:0]   pending_d;

    logic                  out_valid_q;
    logic [REG_WIDTH-1:0]  out_reg_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_last_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  drop_q;

    logic                  wb_we_c;
    logic                  beat_fire_c;
    logic [REG_WIDTH-1:0]  nxt_idx_c;
    logic [DATA_WIDTH-1:0] nxt_data_c;
    logic                  nxt_last_c;

    assign beat_fire_c = out_valid_q && out_if.out_ready_i;

    // Next pending set and snapshot, then the beat those imply for the next cycle.
    always_comb begin
        wb_we_c = wb_enable_i && !(R0_ZERO && (wb_reg_i == '0));
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            shadow_fwd_c[i] = (wb_we_c && (wb_reg_i == REG_WIDTH'(i))) ? wb_data_i : shadow_q[i];
        end

        pending_d = pending_q;
        snap_d    = snap_q;
        if ((state_q == ST_IDLE) && trig_i) begin
            pending_d = trig_mask_i;
            snap_d    = shadow_fwd_c;
        end else if ((state_q == ST_SEND) && beat_fire_c) begin
            pending_d = pending_q & ~(NUM_REGS'(1) << out_reg_q);
        end

        nxt_idx_c = '0;
        for (int i = int'(NUM_REGS) - 1; i >= 0; i--) begin
            if (pending_d[i]) begin
                nxt_idx_c = REG_WIDTH'(i);
            end
        end
        nxt_data_c = snap_d[nxt_idx_c];
        nxt_last_c = ((pending_d & (pending_d - NUM_REGS'(1))) == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                shadow_q[i] <= '0;
                snap_q[i]   <= '0;
            end
            out_valid_q <= 1'b0;
            out_reg_q   <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            if (wb_we_c) begin
                shadow_q[wb_reg_i] <= wb_data_i;
            end
            pending_q <= pending_d;
            snap_q    <= snap_d;
            done_q    <= 1'b0;
            drop_q    <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (trig_i) begin
                        if (trig_mask_i != '0) begin
                            state_q     <= ST_SEND;
                            busy_q      <= 1'b1;
                            out_valid_q <= 1'b1;
                            out_reg_q   <= nxt_idx_c;
                            out_data_q  <= nxt_data_c;
                            out_last_q  <= nxt_last_c;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    drop_q <= trig_i;
                    if (beat_fire_c) begin
                        if (out_last_q) begin
                            state_q     <= ST_IDLE;
                            busy_q      <= 1'b0;
                            out_valid_q <= 1'b0;
                            out_reg_q   <= '0;
                            out_data_q  <= '0;
                            out_last_q  <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            out_reg_q  <= nxt_idx_c;
                            out_data_q <= nxt_data_c;
                            out_last_q <= nxt_last_c;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_if.out_valid_o = out_valid_q;
    assign out_if.out_reg_o   = out_reg_q;
    assign out_if.out_data_o  = out_data_q;
    assign out_if.out_last_o  = out_last_q;
    assign busy_o             = busy_q;
    assign done_o             = done_q;
    assign trig_dropped_o     = drop_q;

endmodule
